pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generator. It synchronises the asynchronous `pwm_in` line, detects edges, and counts clock cycles to report each complete period and its high (pulse) time. A one-cycle `valid` strobe accompanies each new measurement. A timeout flags a stuck line (0 % or 100 % duty). The block sits between a board-level PWM/fan-tach/servo input and a register interface or control loop.

## Interface
- `CNT_WIDTH`, 16: width of the cycle counters and of the `period` and `pulse_len` outputs.
- `TIMEOUT`, 1024: cycles without an edge before declaring the line stuck. Legal range is 2 to 2^CNT_WIDTH−1.
- `clk`  in  1  sole clock; every flop is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `en`  in  1  capture enable; low forces IDLE.
- `pwm_in`  in  1  asynchronous PWM input.
- `period`  out  CNT_WIDTH  last measured period, in clk cycles.
- `pulse_len`  out  CNT_WIDTH  last measured high time, in clk cycles.
- `valid`  out  1  one-cycle strobe when `period` and `pulse_len` update.
- `timeout`  out  1  sticky flag meaning no edge for TIMEOUT cycles.
- `level`  out  1  synchronised `pwm_in`; meaningful when `timeout`=1.

## Operation
- **Synchroniser:** two flops, `s1` then `s2`, followed by a third flop `s3`.
  - `rise` = `s2 & ~s3`
  - `fall` = `~s2 & s3`
  - `level` = `s2`
  - The synchroniser runs regardless of `en`.
- **States:** IDLE, ARM, HIGH, LOW.
  - IDLE: when `en`=1, go to ARM. Counter is held at 0.
  - ARM: on `rise`, set `cnt`<=1 and go to HIGH. No output update on this first rise.
  - HIGH: `cnt`++. On `fall`, `pulse_len_r`<=`cnt` and go to LOW.
  - LOW: `cnt`++. On `rise`, `period`<=`cnt`, `pulse_len`<=`pulse_len_r`, `valid`<=1, `timeout`<=0, `cnt`<=1, and go to HIGH.
- **Timeout:** in HIGH or LOW, if `cnt`==TIMEOUT and there is no edge this cycle:
  - `timeout`<=1, `cnt`<=0, go to ARM;
  - `period` and `pulse_len` hold.
  - In ARM the counter also runs. `timeout` is set again after each further TIMEOUT cycles with no rise; it is idempotent.
- **Clear of `timeout`:** only on the next `valid` or on reset.
- **Simultaneous edge and timeout:** the edge wins and the timeout is not taken.
- **`en` falling:**
  - The next state is IDLE from any state and any partial measurement is discarded.
  - `period`, `pulse_len` and `timeout` hold.
  - `valid` is 0.
- **Width rule:**
  - `cnt` is CNT_WIDTH bits and never wraps, because the timeout fires first.
  - Reported values are exact cycle counts: both edges see the same synchroniser latency.
- **Glitches:** pulses shorter than one clk period may be missed; this is accepted.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, `s1`/`s2`/`s3`=0, `period`=0, `pulse_len`=0, `valid`=0, `timeout`=0, `level`=0.
- **Edge latency:** a change on `pwm_in` before clk edge k is seen as `rise`/`fall` in the cycle after edge k+1.
- **`valid` latency:** `valid` is asserted in the cycle after the `rise` that closes a period, which is edge k+2 relative to the input rise. Outputs are registered and change in the same cycle as `valid`.
- **Throughput:** one measurement per input period. The minimum measurable period is 2 cycles, with pulse_len ≥1 and low time ≥1.
- **Reset mid-operation:** outputs clear immediately (asynchronous). The first `valid` after reset needs two rises.

## Structure
- **Package `pwm_pkg`:** the state enum (IDLE/ARM/HIGH/LOW) and shared counter-width defaults. The generator may import the same package.
- **Sub-module `pwm_sync_edge`:** the 2-flop synchroniser, delay flop, and `rise`/`fall`/`level` outputs. It is reusable by other capture blocks.

## Test plan
- **Basic measurement:** `en`=1, `pwm_in` at period 16 with 4 high → second and later rises give `valid` pulses 16 cycles apart with `period`=16, `pulse_len`=4. No `valid` on the first rise.
- **Extreme duty cycles:**
  - Period 2, high 1 → `period`=2, `pulse_len`=1 on every `valid`.
  - Period 10, high 9 → `period`=10, `pulse_len`=9.
- **Stuck low:** TIMEOUT=32; after a valid measurement, hold `pwm_in`=0 → `timeout`=1 exactly 32 counts after the last rise, `level`=0, and `period`/`pulse_len` unchanged. On resuming period 16, `timeout` clears with the next `valid`.
- **Stuck high (100 % duty):** hold `pwm_in`=1 → `timeout`=1 and `level`=1. An edge landing in the same cycle as `cnt`==TIMEOUT gives no timeout.
- **`en` toggle:** drop `en` mid-HIGH → no `valid`, and outputs hold. Re-enable → the first `valid` arrives only after two rises, with correct values.
- **Asynchronous reset:** assert `rst`=0 mid-LOW with no clk edge → all outputs go to 0 at once. Release → ARM behaviour is repeated, and the first measurement is correct.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture family.
//   - pwm_state_e : capture FSM states (idle, armed, measuring high, measuring low)
//   - PwmCntWidthDefault / PwmTimeoutDefault : default counter width and
//     stuck-line timeout used by the capture block
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StHigh,
        StLow
    } pwm_state_e;

    localparam int unsigned PwmCntWidthDefault = 16;
    localparam int unsigned PwmTimeoutDefault  = 1024;

endpackage

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Two-flop synchroniser for an asynchronous input, followed by a delay flop
// used for edge detection.
// Ports:
//   clk     : sole clock, rising edge
//   rst     : asynchronous active-low reset
//   sig_i   : asynchronous input
//   level_o : synchronised level (second synchroniser stage)
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Both edges come from the same s2/s3 pair, so rise and fall share one
    // latency and measured intervals are exact.
    always_comb begin
        level_o = s2_q;
        rise_o  = s2_q & ~s3_q;
        fall_o  = ~s2_q & s3_q;
    end

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Ports:
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-low reset
//   en        : capture enable; low returns to idle and discards partial data
//   pwm_in    : asynchronous PWM input
//   period    : last measured period (rise to rise), in clk cycles
//   pulse_len : last measured high time (rise to fall), in clk cycles
//   valid     : one-cycle strobe when period/pulse_len update
//   timeout   : sticky; no edge for TIMEOUT cycles, cleared by next valid
//   level     : synchronised pwm_in, tells stuck-high from stuck-low
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PwmCntWidthDefault,
    parameter int unsigned TIMEOUT   = PwmTimeoutDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] pulse_len,
    output logic                 valid,
    output logic                 timeout,
    output logic                 level
);

    localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

    logic sync_level;
    logic sync_rise;
    logic sync_fall;

    pwm_sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (pwm_in),
        .level_o (sync_level),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    pwm_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pulse_r_q, pulse_r_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 timed_out;

    // Saturating increment: a fall landing exactly on the timeout count
    // pushes cnt one past TIMEOUT, so the limit test below is >= and the
    // counter must never wrap back under it.
    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
        timed_out = (cnt_q >= TimeoutCnt);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_r_d   = pulse_r_q;
        period_d    = period_q;
        pulse_len_d = pulse_len_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArm;
                    cnt_d   = '0;
                end

                // First rise only starts a measurement; nothing reported.
                StArm: begin
                    if (sync_rise) begin
                        cnt_d   = CntOne;
                        state_d = StHigh;
                    end else if (timed_out) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                // Edge checks come before the timeout so an edge on the
                // limit cycle still counts as a normal edge.
                StHigh: begin
                    if (sync_fall) begin
                        pulse_r_d = cnt_q;
                        cnt_d     = cnt_inc;
                        state_d   = StLow;
                    end else if (timed_out) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = StArm;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                StLow: begin
                    if (sync_rise) begin
                        period_d    = cnt_q;
                        pulse_len_d = pulse_r_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = CntOne;
                        state_d     = StHigh;
                    end else if (timed_out) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = StArm;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_r_q   <= '0;
            period_q    <= '0;
            pulse_len_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_r_q   <= pulse_r_d;
            period_q    <= period_d;
            pulse_len_q <= pulse_len_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        period    = period_q;
        pulse_len = pulse_len_q;
        valid     = valid_q;
        timeout   = timeout_q;
        level     = sync_level;
    end

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Directed stimulus for pwm_capture with a timestamp-based reference model
// compared against the DUT every cycle, plus literal checks at segment ends.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 32;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          en     = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] pulse_len;
    logic          valid;
    logic          timeout;
    logic          level;

    pwm_capture #(
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .period    (period),
        .pulse_len (pulse_len),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps, not counters) -----------
    localparam int MOff = 0, MWait = 1, MHigh = 2, MLow = 3;
    bit      p1 = 0, p2 = 0, p3 = 0;   // samples of pwm_in 1, 2, 3 edges ago
    longint  t = 0;
    int      mode = MOff;
    longint  win = 0;                  // start of the armed-wait window
    longint  rise_t = 0;
    longint  pulse_r = 0;
    longint  m_period = 0, m_pulse = 0;
    bit      m_valid = 0, m_timeout = 0, m_level = 0;

    task automatic model_reset();
        p1 = 0; p2 = 0; p3 = 0;
        mode = MOff; win = 0; rise_t = 0; pulse_r = 0;
        m_period = 0; m_pulse = 0; m_valid = 0; m_timeout = 0; m_level = 0;
    endtask

    task automatic model_step();
        bit r, f;
        r = p2 & ~p3;
        f = ~p2 & p3;
        p3 = p2; p2 = p1; p1 = pwm_in;
        t++;
        m_valid = 0;
        if (!en) begin
            mode = MOff;
        end else begin
            case (mode)
                MOff: begin mode = MWait; win = t; end
                MWait: begin
                    if (r) begin mode = MHigh; rise_t = t; end
                    else if (t - win >= TO) begin m_timeout = 1; win = t; end
                end
                MHigh: begin
                    if (f) begin pulse_r = t - rise_t; mode = MLow; end
                    else if (t - rise_t >= TO) begin m_timeout = 1; mode = MWait; win = t; end
                end
                default: begin
                    if (r) begin
                        m_period = t - rise_t; m_pulse = pulse_r;
                        m_valid = 1; m_timeout = 0;
                        rise_t = t; mode = MHigh;
                    end else if (t - rise_t >= TO) begin
                        m_timeout = 1; mode = MWait; win = t;
                    end
                end
            endcase
        end
        m_level = p2;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------- per-cycle compare + observation ----------------------
    int     cyc = 0;
    int     valid_cnt = 0;
    int     last_valid_cyc = 0;
    int     last_interval = 0;
    int     to_gap = -1;
    bit     prev_to = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("period", period, m_period);
            check("pulse_len", pulse_len, m_pulse);
            check("valid", valid, m_valid);
            check("timeout", timeout, m_timeout);
            check("level", level, m_level);
            if (valid) begin
                valid_cnt++;
                last_interval  = cyc - last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if (timeout && !prev_to) to_gap = cyc - last_valid_cyc;
            prev_to = timeout;
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic run_pwm(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            tick(hi);
            pwm_in = 1'b0;
            tick(per - hi);
        end
    endtask

    int v0;

    initial begin
        tick(3);
        check("rst_period", period, 0);
        check("rst_pulse", pulse_len, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_level", level, 0);
        rst = 1'b1;
        tick(2);
        en = 1'b1;
        tick(4);

        // Basic 16/4: six rises give five measurements 16 cycles apart.
        v0 = valid_cnt;
        run_pwm(16, 4, 6);
        tick(4);
        check("basic_nvalid", valid_cnt - v0, 5);
        check("basic_period", period, 16);
        check("basic_pulse", pulse_len, 4);
        check("basic_interval", last_interval, 16);

        // Minimum period.
        v0 = valid_cnt;
        run_pwm(2, 1, 8);
        tick(4);
        check("p2_nvalid", valid_cnt - v0, 8);
        check("p2_period", period, 2);
        check("p2_pulse", pulse_len, 1);

        // 90 % duty.
        run_pwm(10, 9, 5);
        tick(4);
        check("p10_period", period, 10);
        check("p10_pulse", pulse_len, 9);

        // Stuck low.
        tick(45);
        check("stuck_lo_timeout", timeout, 1);
        check("stuck_lo_level", level, 0);
        check("stuck_lo_period", period, 10);
        check("stuck_lo_pulse", pulse_len, 9);
        check("stuck_lo_gap", to_gap, 32);
        v0 = valid_cnt;
        run_pwm(16, 4, 3);
        tick(4);
        check("resume_nvalid", valid_cnt - v0, 2);
        check("resume_timeout", timeout, 0);
        check("resume_period", period, 16);

        // Rise on the exact timeout count: edge wins.
        v0 = valid_cnt;
        run_pwm(32, 8, 3);
        check("edge_win_nvalid", valid_cnt - v0, 3);
        check("edge_win_period", period, 32);
        check("edge_win_pulse", pulse_len, 8);
        check("edge_win_timeout", timeout, 0);

        // Stuck high.
        pwm_in = 1'b1;
        tick(50);
        check("stuck_hi_timeout", timeout, 1);
        check("stuck_hi_level", level, 1);
        check("stuck_hi_period", period, 32);
        pwm_in = 1'b0;
        tick(4);
        run_pwm(16, 4, 3);
        tick(4);
        check("recover_timeout", timeout, 0);
        check("recover_period", period, 16);

        // Enable dropped mid-high.
        run_pwm(16, 4, 2);
        pwm_in = 1'b1;
        tick(5);
        en = 1'b0;
        v0 = valid_cnt;
        tick(2);
        pwm_in = 1'b0;
        tick(12);
        run_pwm(16, 4, 2);
        check("dis_nvalid", valid_cnt - v0, 0);
        check("dis_period", period, 16);
        check("dis_pulse", pulse_len, 4);
        en = 1'b1;
        tick(3);
        v0 = valid_cnt;
        run_pwm(12, 5, 4);
        tick(4);
        check("reen_nvalid", valid_cnt - v0, 3);
        check("reen_period", period, 12);
        check("reen_pulse", pulse_len, 5);

        // Asynchronous reset in the low phase, between clock edges.
        run_pwm(16, 4, 2);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(6);
        #1 rst = 1'b0;
        #1;
        check("arst_period", period, 0);
        check("arst_pulse", pulse_len, 0);
        check("arst_valid", valid, 0);
        check("arst_timeout", timeout, 0);
        check("arst_level", level, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        v0 = valid_cnt;
        run_pwm(16, 4, 4);
        tick(4);
        check("post_rst_nvalid", valid_cnt - v0, 3);
        check("post_rst_period", period, 16);
        check("post_rst_pulse", pulse_len, 4);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
